// File: rtl/bus_dev_endpoint_if.sv
// Device-endpoint bundle: host-side TX write / RX read plus bus-side pndng/pop and push.
// The slave modport is the endpoint; the master modport is whoever drives it.
interface bus_dev_endpoint_if #(
   parameter int pckg_sz = 16,
   parameter int depth   = 8
);
   localparam int CW = $clog2(depth + 1);

   logic               wr_en;
   logic [pckg_sz-1:0] wr_data;
   logic               tx_full;
   logic [CW-1:0]      tx_count;
   logic               pndng;
   logic               pop;
   logic [pckg_sz-1:0] D_pop;
   logic               push;
   logic [pckg_sz-1:0] D_push;
   logic               rx_valid;
   logic [pckg_sz-1:0] rx_data;
   logic               rx_ready;
   logic [CW-1:0]      rx_count;
   logic [3:0]         err_flags;

   modport slave (
      input  wr_en, wr_data, pop, push, D_push, rx_ready,
      output tx_full, tx_count, pndng, D_pop, rx_valid, rx_data, rx_count, err_flags
   );

   modport master (
      output wr_en, wr_data, pop, push, D_push, rx_ready,
      input  tx_full, tx_count, pndng, D_pop, rx_valid, rx_data, rx_count, err_flags
   );
endinterface

// File: rtl/bus_dev_endpoint.sv
// Bus device endpoint: show-ahead TX FIFO drained by the bus, show-ahead RX FIFO
// filled by bus pushes addressed to dev_id or broadcast, and sticky error flags.
module bus_dev_endpoint #(
   parameter int         pckg_sz = 16,
   parameter int         depth   = 8,
   parameter logic [7:0] dev_id  = 8'd0
) (
   input  logic              clk,
   input  logic              reset,
   bus_dev_endpoint_if.slave bus
);
   localparam int            CW       = $clog2(depth + 1);
   localparam int            AW       = $clog2(depth);
   localparam logic [CW-1:0] FULL_CNT = CW'(depth);

   logic [pckg_sz-1:0] tx_mem [depth];
   logic [pckg_sz-1:0] rx_mem [depth];

   logic [AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
   logic [AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
   logic [3:0]    err_q, err_d;

   logic       tx_empty, tx_full, tx_push, tx_pop;
   logic       rx_empty, rx_full, rx_push, rx_pop, rx_match;
   logic [7:0] rx_dst;

   always_comb begin
      tx_empty = (tx_cnt_q == '0);
      tx_full  = (tx_cnt_q == FULL_CNT);
      rx_empty = (rx_cnt_q == '0);
      rx_full  = (rx_cnt_q == FULL_CNT);
      rx_dst   = bus.D_push[pckg_sz-1 -: 8];
      rx_match = (rx_dst == dev_id) || (rx_dst == 8'hFF);

      // A same-cycle dequeue frees the slot, so a full FIFO can still accept.
      tx_pop  = bus.pop && !tx_empty;
      tx_push = bus.wr_en && (!tx_full || tx_pop);
      rx_pop  = bus.rx_ready && !rx_empty;
      rx_push = bus.push && rx_match && (!rx_full || rx_pop);

      tx_wr_d  = tx_push ? tx_wr_q + AW'(1) : tx_wr_q;
      tx_rd_d  = tx_pop  ? tx_rd_q + AW'(1) : tx_rd_q;
      rx_wr_d  = rx_push ? rx_wr_q + AW'(1) : rx_wr_q;
      rx_rd_d  = rx_pop  ? rx_rd_q + AW'(1) : rx_rd_q;

      tx_cnt_d = tx_cnt_q;
      case ({tx_push, tx_pop})
         2'b10:   tx_cnt_d = tx_cnt_q + CW'(1);
         2'b01:   tx_cnt_d = tx_cnt_q - CW'(1);
         default: tx_cnt_d = tx_cnt_q;
      endcase

      rx_cnt_d = rx_cnt_q;
      case ({rx_push, rx_pop})
         2'b10:   rx_cnt_d = rx_cnt_q + CW'(1);
         2'b01:   rx_cnt_d = rx_cnt_q - CW'(1);
         default: rx_cnt_d = rx_cnt_q;
      endcase

      err_d = err_q | {bus.push && !rx_match,
                       bus.push && rx_match && rx_full && !rx_pop,
                       bus.pop && tx_empty,
                       bus.wr_en && tx_full && !tx_pop};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_wr_q  <= '0;
         tx_rd_q  <= '0;
         rx_wr_q  <= '0;
         rx_rd_q  <= '0;
         tx_cnt_q <= '0;
         rx_cnt_q <= '0;
         err_q    <= '0;
      end else begin
         tx_wr_q  <= tx_wr_d;
         tx_rd_q  <= tx_rd_d;
         rx_wr_q  <= rx_wr_d;
         rx_rd_q  <= rx_rd_d;
         tx_cnt_q <= tx_cnt_d;
         rx_cnt_q <= rx_cnt_d;
         err_q    <= err_d;
      end
   end

   // Storage is unreset; empty FIFOs mask their head to zero instead.
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr_q] <= bus.wr_data;
      if (rx_push) rx_mem[rx_wr_q] <= bus.D_push;
   end

   assign bus.tx_full   = tx_full;
   assign bus.tx_count  = tx_cnt_q;
   assign bus.pndng     = !tx_empty;
   assign bus.D_pop     = tx_empty ? '0 : tx_mem[tx_rd_q];
   assign bus.rx_valid  = !rx_empty;
   assign bus.rx_data   = rx_empty ? '0 : rx_mem[rx_rd_q];
   assign bus.rx_count  = rx_cnt_q;
   assign bus.err_flags = err_q;
endmodule
